wb_regfile: RTL and testbench

- Write-back stage and architectural register file. It consumes the MEM/WB pipeline register outputs and is the receiving end of that interface.
- Selects the write-back value (ALU result, loaded word or loaded byte) and commits it to one of 16 general registers.
- Separately commits the R15 secondary result, produced by multiply/divide.
- Provides two combinational read ports with write-through bypass to the decode stage.

---
 rtl/wb_regfile_if.sv | 38 +++
 rtl/wb_regfile.sv | 79 +++++++
 tb/tb_wb_regfile.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Purpose : MEM/WB-to-register-file bundle plus the decode-side read ports.
// Latency : wiring only; no storage.
// Backpr. : none; every write presented is accepted on the next clk edge.
// Ports   : master = pipeline/decode side, slave = wb_regfile.
//   regWrite/R15Write/MemtoReg/loadByte  write controls
//   readData/res/R15_data                candidate write-back values
//   regDes/rdAddr1/rdAddr2               destination and read addresses
//   rdData1/rdData2/wbData               read data and forwarded write-back value
interface wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();
  logic              regWrite;
  logic              R15Write;
  logic              MemtoReg;
  logic              loadByte;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] R15_data;
  logic [ADDR_W-1:0] regDes;
  logic [ADDR_W-1:0] rdAddr1;
  logic [ADDR_W-1:0] rdAddr2;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic [DATA_W-1:0] wbData;

  modport master (
    output regWrite, R15Write, MemtoReg, loadByte,
    output readData, res, R15_data, regDes, rdAddr1, rdAddr2,
    input  rdData1, rdData2, wbData
  );

  modport slave (
    input  regWrite, R15Write, MemtoReg, loadByte,
    input  readData, res, R15_data, regDes, rdAddr1, rdAddr2,
    output rdData1, rdData2, wbData
  );
endinterface

// File: rtl/wb_regfile.sv
// Purpose : write-back select and 2**ADDR_W x DATA_W register file, two bypassed read ports.
// Latency : writes commit on the next rising clk; reads and wbData are combinational.
// Backpr. : none; all asserted writes are taken every edge.
// Ports   : clk, rst (async, active-low) plus wb_regfile_if.slave bus carrying
//           the MEM/WB write controls/data, read addresses and read/forward data.
module wb_regfile #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int LB_SIGN_EXT = 1,
  parameter int R15_IDX     = 15
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int              NREG  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R15_A = ADDR_W'(R15_IDX);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] wb_data;
  logic              byte_ext;

  // Upper byte fill for loadByte: copies of bit 7 or zeros.
  assign byte_ext = (LB_SIGN_EXT != 0) ? bus.readData[7] : 1'b0;

  always_comb begin
    wb_data = bus.res;
    if (bus.MemtoReg) begin
      if (bus.loadByte) begin
        wb_data = {{(DATA_W-8){byte_ext}}, bus.readData[7:0]};
      end else begin
        wb_data = bus.readData;
      end
    end
  end

  assign bus.wbData = wb_data;

  // The R15 write is applied last so it overrides a general write to the
  // same register.
  always_comb begin
    regs_d = regs_q;
    if (bus.regWrite) begin
      regs_d[bus.regDes] = wb_data;
    end
    if (bus.R15Write) begin
      regs_d[R15_A] = bus.R15_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass priority mirrors the write priority: R15 port, then general port,
  // then stored value. Reads are forced to zero while reset is held.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (bus.R15Write && (addr == R15_A)) begin
      val = bus.R15_data;
    end else if (bus.regWrite && (addr == bus.regDes)) begin
      val = wb_data;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  assign bus.rdData1 = rst ? read_port(bus.rdAddr1) : '0;
  assign bus.rdData2 = rst ? read_port(bus.rdAddr2) : '0;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  wb_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus_z ();

  // Second instance with zero-extending loadByte shares all inputs.
  assign bus_z.regWrite = bus.regWrite;
  assign bus_z.R15Write = bus.R15Write;
  assign bus_z.MemtoReg = bus.MemtoReg;
  assign bus_z.loadByte = bus.loadByte;
  assign bus_z.readData = bus.readData;
  assign bus_z.res      = bus.res;
  assign bus_z.R15_data = bus.R15_data;
  assign bus_z.regDes   = bus.regDes;
  assign bus_z.rdAddr1  = bus.rdAddr1;
  assign bus_z.rdAddr2  = bus.rdAddr2;

  wb_regfile #(.DATA_W(16), .ADDR_W(4), .LB_SIGN_EXT(1), .R15_IDX(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_regfile #(.DATA_W(16), .ADDR_W(4), .LB_SIGN_EXT(0), .R15_IDX(15)) u_dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] wb;
    logic [15:0] wbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic chk_vld = 1'b0;

  task automatic cmp(input string name, input string fld, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, fld, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the commit edge.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: strobe with empty queue, got %0d entries, expected >0", exp_q.size());
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "rdData1", bus.rdData1, e.rd1);
        cmp(e.name, "rdData2", bus.rdData2, e.rd2);
        cmp(e.name, "wbData",  bus.wbData,  e.wb);
        cmp(e.name, "wbData_zext", bus_z.wbData, e.wbz);
      end
    end
  end

  // One cycle: drive just after the rising edge, expect results before the next.
  task automatic cyc(
    input string       name,
    input logic        rst_v,
    input logic        rw, input logic r15w, input logic m2r, input logic lb,
    input logic [15:0] rdat, input logic [15:0] rres, input logic [15:0] r15d,
    input logic [3:0]  des, input logic [3:0] a1, input logic [3:0] a2,
    input logic [15:0] e_rd1, input logic [15:0] e_rd2,
    input logic [15:0] e_wb,  input logic [15:0] e_wbz
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst          = rst_v;
    bus.regWrite = rw;
    bus.R15Write = r15w;
    bus.MemtoReg = m2r;
    bus.loadByte = lb;
    bus.readData = rdat;
    bus.res      = rres;
    bus.R15_data = r15d;
    bus.regDes   = des;
    bus.rdAddr1  = a1;
    bus.rdAddr2  = a2;
    e.name = name; e.rd1 = e_rd1; e.rd2 = e_rd2; e.wb = e_wb; e.wbz = e_wbz;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.regWrite = 1'b0; bus.R15Write = 1'b0; bus.MemtoReg = 1'b0; bus.loadByte = 1'b0;
    bus.readData = '0; bus.res = '0; bus.R15_data = '0;
    bus.regDes = '0; bus.rdAddr1 = '0; bus.rdAddr2 = '0;

    //   name          rst rw r15 m2r lb readData res      R15_data des a1 a2  rd1      rd2      wb       wbz
    cyc("reset_state", 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 15, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cyc("wr_r3",       1, 1, 0, 0, 0, 16'h0000, 16'h1234, 16'h0000, 3, 3, 0,  16'h1234, 16'h0000, 16'h1234, 16'h1234);
    cyc("rd_r3",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 3,  16'h1234, 16'h1234, 16'h0000, 16'h0000);
    // Reset asserted between edges with a write pending: reads drop at once.
    cyc("rst_mid",     0, 1, 0, 0, 0, 16'h0000, 16'h5555, 16'h0000, 3, 3, 3,  16'h0000, 16'h0000, 16'h5555, 16'h5555);
    cyc("rst_hold",    0, 1, 1, 0, 0, 16'h0000, 16'h5555, 16'h6666, 3, 3, 15, 16'h0000, 16'h0000, 16'h5555, 16'h5555);
    // After release, neither held-reset write may have landed.
    cyc("rst_nowr",    1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 15, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cyc("lb_ext",      1, 1, 0, 1, 1, 16'hAB80, 16'h0000, 16'h0000, 5, 5, 4,  16'hFF80, 16'h0000, 16'hFF80, 16'h0080);
    cyc("lb_stored",   1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 5, 5,  16'hFF80, 16'hFF80, 16'h0000, 16'h0000);
    cyc("ld_word",     1, 1, 0, 1, 0, 16'hDEAD, 16'h0000, 16'h0000, 6, 6, 5,  16'hDEAD, 16'hFF80, 16'hDEAD, 16'hDEAD);
    cyc("src_alu",     1, 0, 0, 0, 1, 16'hDEAD, 16'h00FF, 16'h0000, 0, 5, 6,  16'hFF80, 16'hDEAD, 16'h00FF, 16'h00FF);
    cyc("lb_pos",      1, 0, 0, 1, 1, 16'h127F, 16'h0000, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 16'h007F, 16'h007F);
    cyc("dual_wr",     1, 1, 1, 0, 0, 16'h0000, 16'h0011, 16'h7777, 2, 2, 15, 16'h0011, 16'h7777, 16'h0011, 16'h0011);
    cyc("dual_rd",     1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 2, 15, 16'h0011, 16'h7777, 16'h0000, 16'h0000);
    cyc("conflict",    1, 1, 1, 0, 0, 16'h0000, 16'h1111, 16'h2222, 15, 15, 15, 16'h2222, 16'h2222, 16'h1111, 16'h1111);
    cyc("conflict_rd", 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 15, 2, 16'h2222, 16'h0011, 16'h0000, 16'h0000);
    cyc("wr_r7",       1, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 7, 0, 0,  16'h0000, 16'h0000, 16'h0005, 16'h0005);
    cyc("byp_off",     1, 0, 0, 0, 0, 16'h0000, 16'h0009, 16'h0000, 7, 7, 7,  16'h0005, 16'h0005, 16'h0009, 16'h0009);
    cyc("byp_on",      1, 1, 0, 0, 0, 16'h0000, 16'h0009, 16'h0000, 7, 7, 7,  16'h0009, 16'h0009, 16'h0009, 16'h0009);
    cyc("byp_commit",  1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 7, 5,  16'h0009, 16'hFF80, 16'h0000, 16'h0000);
    cyc("r15_prio",    1, 1, 1, 0, 0, 16'h0000, 16'h4444, 16'h3333, 4, 15, 4, 16'h3333, 16'h4444, 16'h4444, 16'h4444);
    cyc("wr_r0",       1, 1, 0, 0, 0, 16'h0000, 16'hABCD, 16'h0000, 0, 4, 15, 16'h4444, 16'h3333, 16'hABCD, 16'hABCD);
    cyc("rd_r0",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3,  16'hABCD, 16'h0000, 16'h0000, 16'h0000);

    @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
